// File: rtl/simple_decoder_pkg.sv
// Shared types and constants for the simple_decoder receive-side block.
package simple_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int unsigned SYNC_MIN = 1;
  localparam int unsigned SYNC_MAX = 8;
  localparam int unsigned FILL_W   = $clog2(SYNC_MAX + 1);

endpackage

// File: rtl/simple_decoder_if.sv
// Encoder-line input and decoded results of simple_decoder.
interface simple_decoder_if #(
  parameter int unsigned CNT_W = 8
);

  logic             inp;
  logic             and_out;
  logic             and_valid;
  logic             err;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output inp,
    input  and_out, and_valid, err, pulse_cnt
  );

  modport slave (
    input  inp,
    output and_out, and_valid, err, pulse_cnt
  );

endinterface

// File: rtl/simple_sync_pipe.sv
// STAGES-deep 1-bit shift register with synchronous active-high reset.
module simple_sync_pipe #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/simple_decoder.sv
// Decodes the simple encoder's out line; flags back-to-back 1s as errors.
// Optional saturating pulse counter compiled in with SIMPLE_DECODER_CNT_EN.
module simple_decoder
  import simple_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           tau2015_clk,
  input  logic           rst,
  simple_decoder_if.slave bus
);

  logic              s;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              fill_active;
  state_t            state_q, state_d;
  logic              and_out_q, and_out_d;
  logic              and_valid_q, and_valid_d;
  logic              err_q, err_d;

  simple_sync_pipe #(.STAGES(SYNC_STAGES)) u_pipe (
    .clk (tau2015_clk),
    .rst (rst),
    .d   (bus.inp),
    .q   (s)
  );

  assign fill_active = (fill_q != '0);

  // Next state and next registered outputs; fill masks the reset zeros in the pipe.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    and_out_d   = 1'b0;
    and_valid_d = 1'b0;
    err_d       = 1'b0;
    if (fill_active) begin
      fill_d  = fill_q - FILL_W'(1);
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          and_valid_d = 1'b1;
          if (s) begin
            and_out_d = 1'b1;
            state_d   = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (s) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ERR: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_q      <= FILL_W'(SYNC_STAGES);
      and_out_q   <= 1'b0;
      and_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      and_out_q   <= and_out_d;
      and_valid_q <= and_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.and_out   = and_out_q;
  assign bus.and_valid = and_valid_q;
  assign bus.err       = err_q;

`ifdef SIMPLE_DECODER_CNT_EN
  logic             cnt_inc_c;
  logic [CNT_W-1:0] cnt_q;

  assign cnt_inc_c = !fill_active && (state_q == ST_IDLE) && s;

  // Saturating count of decoded 1s; frozen outside the IDLE/s=1 decision.
  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_inc_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pulse_cnt = cnt_q;
`else
  assign bus.pulse_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_simple_decoder.sv
// Directed self-checking bench for simple_decoder (SYNC_STAGES=2, CNT_W=4).
module tb_simple_decoder;

  localparam int unsigned CNT_W = 4;
`ifdef SIMPLE_DECODER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  simple_decoder_if #(.CNT_W(CNT_W)) bus ();

  simple_decoder #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .tau2015_clk (clk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present v at the next rising edge, then settle 1 time unit past it.
  task automatic tick(input logic v);
    bus.inp = v;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic v, input logic ev, input logic eo);
    tick(v);
    check({tag, ".valid"}, 32'(bus.and_valid), 32'(ev));
    check({tag, ".out"},   32'(bus.and_out),   32'(eo));
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic reset_and_fill();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    tick_chk("fill1", 1'b0, 1'b0, 1'b0);
    tick_chk("fill2", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    bus.inp = 1'b1;

    // Reset held 3 edges with inp=1
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    check("rst.out",   32'(bus.and_out),   32'd0);
    check("rst.valid", 32'(bus.and_valid), 32'd0);
    check("rst.err",   32'(bus.err),       32'd0);
    check("rst.cnt",   32'(bus.pulse_cnt), 32'd0);

    rst = 1'b0;
    tick_chk("rel1", 1'b0, 1'b0, 1'b0);
    tick_chk("rel2", 1'b0, 1'b0, 1'b0);
    tick_chk("rel3", 1'b0, 1'b1, 1'b0);

    // Steady zero
    for (int i = 0; i < 5; i++) begin
      tick_chk("zero", 1'b0, 1'b1, 1'b0);
      check("zero.cnt", 32'(bus.pulse_cnt), 32'd0);
    end

    // Legal pulses 1,0,1,0 at edges k..k+3
    tick_chk("leg_k0", 1'b1, 1'b1, 1'b0);
    tick_chk("leg_k1", 1'b0, 1'b1, 1'b0);
    tick_chk("leg_k2", 1'b1, 1'b1, 1'b1);
    tick_chk("leg_k3", 1'b0, 1'b0, 1'b0);
    tick_chk("leg_k4", 1'b0, 1'b1, 1'b1);
    tick_chk("leg_k5", 1'b0, 1'b0, 1'b0);
    tick_chk("leg_k6", 1'b0, 1'b1, 1'b0);
    check("leg.cnt", 32'(bus.pulse_cnt), exp_cnt(2));
    check("leg.err", 32'(bus.err), 32'd0);

    // Violation 1,1,0,0 from a clean reset
    reset_and_fill();
    check("viol.cnt0", 32'(bus.pulse_cnt), 32'd0);
    tick_chk("viol_k0", 1'b1, 1'b1, 1'b0);
    tick_chk("viol_k1", 1'b1, 1'b1, 1'b0);
    tick_chk("viol_k2", 1'b0, 1'b1, 1'b1);
    check("viol_k2.err", 32'(bus.err), 32'd0);
    tick_chk("viol_k3", 1'b0, 1'b0, 1'b0);
    check("viol_k3.err", 32'(bus.err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick_chk("viol_hold", (i % 2) == 0, 1'b0, 1'b0);
      check("viol_hold.err", 32'(bus.err), 32'd1);
      check("viol_hold.cnt", 32'(bus.pulse_cnt), exp_cnt(1));
    end

    // One-edge reset while in ERR
    rst = 1'b1;
    tick(1'b0);
    check("mrst.err",   32'(bus.err),       32'd0);
    check("mrst.cnt",   32'(bus.pulse_cnt), 32'd0);
    check("mrst.valid", 32'(bus.and_valid), 32'd0);
    rst = 1'b0;
    tick_chk("mrst_f1", 1'b0, 1'b0, 1'b0);
    tick_chk("mrst_f2", 1'b0, 1'b0, 1'b0);
    tick_chk("mrst_run", 1'b0, 1'b1, 1'b0);
    check("mrst_run.err", 32'(bus.err), 32'd0);

    // Saturation: 8 pairs, then 12 more, then one more
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    tick(1'b0);
    tick(1'b0);
    check("sat8.cnt", 32'(bus.pulse_cnt), exp_cnt(8));
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    tick(1'b0);
    tick(1'b0);
    check("sat20.cnt", 32'(bus.pulse_cnt), exp_cnt(15));
    check("sat20.err", 32'(bus.err), 32'd0);
    tick_chk("sat_p0", 1'b1, 1'b1, 1'b0);
    tick_chk("sat_p1", 1'b0, 1'b1, 1'b0);
    tick_chk("sat_p2", 1'b0, 1'b1, 1'b1);
    tick_chk("sat_p3", 1'b0, 1'b0, 1'b0);
    check("sat_hold.cnt", 32'(bus.pulse_cnt), exp_cnt(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_decoder.md
# simple_decoder

Receive-side counterpart to the `simple` encoder benchmark. It samples the encoder's single-bit `out` line and reconstructs the encoded `inp1 & inp2` condition. It also flags protocol violations and counts decoded pulses. The encoder's flop obeys q_next = (inp1 & inp2) & ~q, so a 1 is always followed by a 0. The decoder exploits this and marks the cycle after every 1 as a blind (non-informative) cycle. The block sits at the far end of the inverter delay chain, with its own input register pipeline to absorb routing delay for retiming and pipelining experiments.

## Interface
- `SYNC_STAGES`, default 2: depth of the input register pipeline; legal range 1..8.
- `CNT_W`, default 8: width of the pulse counter.
- `tau2015_clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `inp`  input  1  encoder `out` line.
- `and_out`  output  1  decoded `inp1 & inp2`; meaningful only when `and_valid`=1.
- `and_valid`  output  1  high when `and_out` carries information.
- `err`  output  1  sticky protocol violation (two consecutive 1s).
- `pulse_cnt`  output  CNT_W  saturating count of decoded 1s.

## Operation
- `inp` passes through SYNC_STAGES flops; the last stage output is the sample s.
- FSM states:
  - IDLE: previous sample was 0, so the current sample is informative.
  - HIGH: previous sample was 1, so this is a blind cycle.
  - ERR: terminal state until reset.
- Transitions and registered outputs on each edge, outside fill:
  - IDLE, s=1: `and_out`=1, `and_valid`=1, next state HIGH, `pulse_cnt` increments.
  - IDLE, s=0: `and_out`=0, `and_valid`=1, stay in IDLE.
  - HIGH, s=0: `and_valid`=0, `and_out`=0, next state IDLE.
  - HIGH, s=1: `err`=1, `and_valid`=0, next state ERR.
  - ERR, any s: `and_valid`=0, `and_out`=0, `err`=1.
- Fill:
  - A down-counter loads SYNC_STAGES on reset.
  - While it is nonzero, the FSM holds IDLE, `and_valid`=0, `and_out`=0, and `pulse_cnt` does not change.
  - This prevents reset zeros in the pipeline from being decoded as data.
- `pulse_cnt`:
  - Unsigned, increments by 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Also increments in the IDLE, s=1 case when the saturation limit has not been reached.
- `err` does not clear `pulse_cnt`; the counter freezes while in ERR.

## Timing
- Reset values after any edge with `rst`=1:
  - All pipeline flops 0, state IDLE, fill counter = SYNC_STAGES.
  - `and_out`=0, `and_valid`=0, `err`=0, `pulse_cnt`=0.
- `rst` overrides every other event, including mid-operation in HIGH or ERR. Fill restarts.
- Latency: the `inp` value present at edge k is reflected on `and_out`/`and_valid`/`err` after edge k+SYNC_STAGES.
- If `rst`'s last high edge is r:
  - `and_valid` stays 0 after edges r+1 .. r+SYNC_STAGES.
  - The first possible `and_valid`=1 is after edge r+SYNC_STAGES+1.
- All outputs are registered. There is no combinational path from `inp` to any output.
- One decision per clock with no stalls. The block has no backpressure.

## Configuration
- `SIMPLE_DECODER_CNT_EN` defined: the pulse counter and its saturation logic are compiled in, and `pulse_cnt` behaves as above.
- Not defined: no counter flops exist, `pulse_cnt` is tied to all zeros, and all other behaviour is identical.

## Structure
- `simple_decoder_pkg` holds:
  - the FSM state enum (IDLE, HIGH, ERR);
  - the SYNC_STAGES legal bounds;
  - the fill counter width constant (`$clog2(8+1)`).
- Sub-module `simple_sync_pipe`:
  - parameterised SYNC_STAGES-deep 1-bit shift register with synchronous reset;
  - reusable for other receive-side benchmarks.
- The top level holds the fill counter, the FSM, the output registers, and the optional counter.

## Test plan
All scenarios use SYNC_STAGES=2, CNT_W=4, macro defined.
- Reset: hold `rst`=1 for 3 edges with `inp`=1 -> all outputs 0. After release, `and_valid`=0 for 2 edges, then 1 on the next.
- Steady zero: after fill, `inp`=0 for 5 cycles -> `and_valid`=1 and `and_out`=0 every cycle; `pulse_cnt`=0.
- Legal pulses: `inp`=1,0,1,0 starting at edge k:
  - `and_out`/`and_valid` = 1/1, 0/0, 1/1, 0/0 after edges k+2..k+5;
  - `pulse_cnt`=2.
- Violation: `inp`=1,1,0,0 -> `err`=1 after edge k+3 and remains 1. `and_valid` stays 0 afterwards. `pulse_cnt` stays 1.
- Saturation: 20 pairs of 1,0 -> `pulse_cnt` reaches 15 and holds 15.
- Mid-run reset in ERR: pulse `rst` for one edge -> after that edge `err`=0, `pulse_cnt`=0, fill restarts. Repeat with the macro undefined -> `pulse_cnt` is 0 throughout.
